// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq -- sequential packed-BCD to binary converter (reverse double-dabble).
//
// One bit of the binary result is produced per CONV cycle: the {digits, binary}
// register pair is shifted right by one, then every digit that now reads >= 8
// has 3 subtracted. After BIN_W iterations the binary register holds the value.
// One extra CONV cycle copies the result into bin_out on the way into DONE.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   convert bcd_in (ignored unless idle)
//   bcd_in   in   4*DIGITS packed BCD, digit 0 in [3:0]
//   busy     out  high in CONV and DONE
//   done     out  one-cycle pulse, bin_out/err valid
//   bin_out  out  BIN_W result, held until the next done
//   err      out  invalid-digit flag, qualified by done
//
// Build option: define BCD2BIN_ERR_EN to reject operands holding a digit > 9
// (done one cycle after acceptance with err=1, bin_out=0). Without it, err is
// tied low and such operands run through the normal algorithm.

// Per-digit correction after the shift: the bit shifted in from the next
// digit up is worth 5 but lands with weight 8, so take 3 back off.
module bcd2bin_seq_dfix (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd8) ? d - 4'd3 : d;
endmodule

module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                   state, state_nx;
  logic [DIGITS-1:0][3:0]   dig, dig_sh, dig_fix;
  logic [BIN_W-1:0]         bin, bin_sh;
  logic [CW-1:0]            cnt;
  logic                     bad;
  logic                     last;

  // Shift the whole {digits, binary} pair right by one; binary LSB falls off.
  assign {dig_sh, bin_sh} = {1'b0, dig, bin[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    bcd2bin_seq_dfix u_fix (.d(dig_sh[g]), .q(dig_fix[g]));
  end

  // Counter reaching BIN_W marks the hand-off cycle (no shift).
  assign last = (cnt == CW'(BIN_W));

`ifdef BCD2BIN_ERR_EN
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
  end
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = bad ? DONE : CONV;
      CONV:    if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dig     <= '0;
      bin     <= '0;
      cnt     <= '0;
      bin_out <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          dig <= bcd_in;
          bin <= '0;
          cnt <= '0;
          // Rejected operand enters DONE straight away with a zero result.
          if (bad) bin_out <= '0;
        end
        CONV: if (last) begin
          bin_out <= bin;
        end else begin
          dig <= dig_fix;
          bin <= bin_sh;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BCD2BIN_ERR_EN
  logic err_q;
  // Captured at acceptance; only looked at while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err_q <= 1'b0;
    else if (state == IDLE && start) err_q <= bad;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [11:0]       bcd_in;
  logic              busy, done, err;
  logic [BIN_W-1:0]  bin_out;

  int checks = 0;
  int errors = 0;

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Transaction-level model: edge numbers of the last acceptance and of the
  // edge after which done is shown; busy spans the cycles after edges acc..dn.
  int cyc = 0;
  int acc = -100, dn = -100;
  int eb = 0;    bit ebk = 1'b1;   bit eerr = 1'b0;
  int pv = 0;    bit pk  = 1'b1;   bit pe   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    cyc++;
    if (!rst_n) begin
      acc = -100; dn = -100; eb = 0; ebk = 1'b1; eerr = 1'b0;
    end else begin
      if (start && !(acc <= cyc - 1 && cyc - 1 <= dn)) begin
        bit valid;
        valid = 1'b1;
        pv = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
          if (bcd_in[4*i +: 4] > 4'd9) valid = 1'b0;
          pv = pv * 10 + int'(bcd_in[4*i +: 4]);
        end
        acc = cyc;
`ifdef BCD2BIN_ERR_EN
        pk = 1'b1; pe = !valid;
        if (!valid) pv = 0;
        dn = valid ? cyc + BIN_W + 1 : cyc;
`else
        pk = valid; pe = 1'b0;
        dn = cyc + BIN_W + 1;
`endif
      end
      if (cyc == dn) begin eb = pv; ebk = pk; eerr = pe; end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), int'(acc <= cyc && cyc <= dn));
      chk("done", int'(done), int'(cyc == dn));
      if (ebk) chk("bin_out", int'(bin_out), eb);
`ifdef BCD2BIN_ERR_EN
      if (cyc == dn) chk("err", int'(err), int'(eerr));
`else
      chk("err", int'(err), 0);
`endif
    end
  end

  // Start one conversion from idle and pin latency/result to literal values.
  task automatic conv(input logic [11:0] b, input int ev, input int el,
                      input bit vchk, input bit ee);
    int lat;
    @(negedge clk); start = 1'b1; bcd_in = b;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin @(negedge clk); lat++; end
    chk("lat", lat, el);
    if (vchk) chk("val", int'(bin_out), ev);
    chk("err_at_done", int'(err), int'(ee));
  endtask

  initial begin
    int last_d, ndone, nd2;
    rst_n = 1'b0; start = 1'b0; bcd_in = '0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    conv(12'h999, 999, BIN_W + 1, 1'b1, 1'b0);
    conv(12'h000, 0,   BIN_W + 1, 1'b1, 1'b0);
    conv(12'h255, 255, BIN_W + 1, 1'b1, 1'b0);
    conv(12'h100, 100, BIN_W + 1, 1'b1, 1'b0);

    // start held high with the operand toggling every cycle.
    last_d = -1; ndone = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      start = 1'b1;
      bcd_in = c[0] ? 12'h456 : 12'h123;
      if (done) begin
        ndone++;
        chk("held_val_ok", int'(bin_out == 10'd123 || bin_out == 10'd456), 1);
        if (last_d >= 0) chk("held_spacing_ok", int'(cyc - last_d >= 12), 1);
        last_d = cyc;
      end
    end
    start = 1'b0;
    chk("held_ndone_ok", int'(ndone >= 3), 1);
    repeat (15) @(negedge clk);

    // Reset five cycles into a conversion.
    @(negedge clk); start = 1'b1; bcd_in = 12'h777;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_bin", int'(bin_out), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd2 = 0;
    repeat (15) begin @(negedge clk); if (done) nd2++; end
    chk("abort_no_done", nd2, 0);
    conv(12'h042, 42, BIN_W + 1, 1'b1, 1'b0);

`ifdef BCD2BIN_ERR_EN
    conv(12'h9A0, 0, 0, 1'b1, 1'b1);
`else
    conv(12'h9A0, 0, BIN_W + 1, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 1000; i++) conv(to_bcd(i), i, BIN_W + 1, 1'b1, 1'b0);

    // Random start pattern, occasional invalid nibbles; model checks each cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) bcd_in = 12'($urandom);
      else bcd_in = to_bcd(int'($urandom_range(0, 999)));
    end
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
